csr_gpio_port: RTL
==================

Name: csr_gpio_port

Overview:
- CSR-side responder for the GPIO interface that the control unit drives.
- Holds the output register written by CSRRW to 0xF00 and drives the HEX displays from it.
- Synchronises and debounces the board switches, and presents the debounced value for CSRRW reads of 0xF02.
- Sits beside the writeback stage: it consumes GPIO_we and the rs1 data, and returns read data to the regsel mux.

Parameters:
- SW_WIDTH, 18, number of switch inputs (1..32).
- HEX_DIGITS, 8, number of 7-segment digits driven (1..8).
- DEBOUNCE_CYCLES, 50000, number of cycles a new switch value must stay constant before it is accepted (>=1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- gpio_we  in  1  write strobe from control (CSRRW to 0xF00).
- gpio_wdata  in  32  data to write (rs1 value).
- sw_raw  in  SW_WIDTH  raw, asynchronous switch pins.
- gpio_rdata  out  32  debounced switches, zero-extended (CSRRW 0xF02 read data).
- gpio_out  out  32  current output register value.
- hex_seg  out  HEX_DIGITS*7  active-low segments; digit i occupies [7i+6:7i], bit order gfedcba.
- sw_changed  out  1  one-cycle pulse when the debounced value updates.

Behaviour:
Reset values (rst_n low, asynchronous):
- gpio_out=0, so every digit of hex_seg shows "0" (7'b1000000).
- Both synchroniser stages are 0.
- sw_stable=0, so gpio_rdata=0.
- sw_changed=0, FSM=STABLE, counter=0.

Write path:
- When gpio_we=1 at a rising edge, gpio_out <= gpio_wdata; the new value is visible the next cycle.
- When gpio_we=0, gpio_out holds.
- Back-to-back writes: last write wins, one per cycle.

HEX decode:
- Combinational from gpio_out: digit i decodes gpio_out[4i+3:4i] for hex 0-F.
- Letters A, b, C, d, E, F use the standard DE-board patterns.

Switch path:
- 2-flop synchroniser per bit: sw_raw -> s1 -> s2.

Debounce FSM, two states, comparing s2 against sw_stable and against a candidate register cand:
- STABLE: if s2 != sw_stable, then cand <= s2, cnt <= DEBOUNCE_CYCLES-1, go to SETTLE. Otherwise stay.
- SETTLE, in priority order:
  - if s2 == sw_stable (bounce back to the old value): go to STABLE, no pulse.
  - else if s2 != cand: cand <= s2, reload cnt.
  - else if cnt==0: sw_stable <= cand, sw_changed=1 for exactly that cycle, go to STABLE.
  - else cnt <= cnt-1.
- Counter width is $clog2(DEBOUNCE_CYCLES)+1, and must not wrap.

Timing:
- Latency from a sw_raw change to the gpio_rdata update is 2 (sync) + 1 (STABLE->SETTLE) + DEBOUNCE_CYCLES cycles, assuming no bounce.
- With DEBOUNCE_CYCLES=1, a change is accepted on the first SETTLE cycle.

Output mapping:
- gpio_rdata = {zeros, sw_stable}, combinational from the register (no added read latency).
- Read and write paths are independent; a simultaneous gpio_we and switch update both take effect.

Reset mid-debounce:
- The in-flight change is discarded and sw_stable returns to 0.
- After release, a non-zero sw_raw is re-debounced from scratch. No sw_changed pulse occurs during reset.

Decomposition:
- Package gpio_pkg holds:
  - localparams CSR_GPIO_OUT=12'hF00 and CSR_GPIO_IN=12'hF02 (shared with ctrl_unit);
  - typedef enum logic {DB_STABLE, DB_SETTLE} db_state_t;
  - SEG_BLANK=7'b1111111.
- One sub-module, hex7seg_decode (4-bit in, 7-bit active-low out), instantiated HEX_DIGITS times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, SW_WIDTH=18):
- Reset then write: assert rst_n low then release; pulse gpio_we with gpio_wdata=32'h0123_4567.
  - Next cycle gpio_out=32'h01234567.
  - Digit0 = 7'b1111000 ("7"), digit7 = 7'b1000000.
  - gpio_rdata=0.
- Clean switch change: set sw_raw=18'h2A5 and hold.
  - gpio_rdata becomes 32'h000002A5 exactly 7 cycles after the change.
  - sw_changed is high for exactly 1 cycle, in the same cycle gpio_rdata updates.
- Bounce rejected: toggle sw_raw between 0 and 18'h1 every 2 cycles for 20 cycles, then return it to 0.
  - gpio_rdata stays 0 and sw_changed never pulses.
- Candidate replaced: sw_raw=18'h3, then after 2 cycles sw_raw=18'h5 and hold.
  - gpio_rdata goes straight to 32'h5 with no intermediate 32'h3, and only one sw_changed pulse occurs.
- Reset mid-operation: with sw_stable=18'h2A5, set sw_raw=18'h0F0, then assert rst_n during SETTLE.
  - Asynchronously gpio_rdata=0 and gpio_out=0.
  - After release, gpio_rdata=32'h0F0 seven cycles later.
- Concurrent activity: gpio_we=1 with gpio_wdata=32'hFFFF_FFFF in the same cycle as a debounce acceptance.
  - Both gpio_out=32'hFFFFFFFF (all digits "F", 7'b0001110) and the new gpio_rdata appear.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO CSR responder: CSR addresses used by the
// control unit, debounce FSM states and the blank segment pattern.
package gpio_pkg;

  localparam logic [11:0] CSR_GPIO_OUT = 12'hF00;
  localparam logic [11:0] CSR_GPIO_IN  = 12'hF02;

  typedef enum logic {
    DB_STABLE,
    DB_SETTLE
  } db_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex7seg_decode.sv
// One 7-segment digit: 4-bit hex value to active-low segments, bit order gfedcba.
module hex7seg_decode
  import gpio_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/csr_gpio_port.sv
// GPIO CSR responder: output register driving the HEX digits, plus a
// synchronised and debounced switch register returned as CSR read data.
module csr_gpio_port
  import gpio_pkg::*;
#(
  parameter int SW_WIDTH        = 18,
  parameter int HEX_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    gpio_we,
  input  logic [31:0]             gpio_wdata,
  input  logic [SW_WIDTH-1:0]     sw_raw,
  output logic [31:0]             gpio_rdata,
  output logic [31:0]             gpio_out,
  output logic [HEX_DIGITS*7-1:0] hex_seg,
  output logic                    sw_changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [31:0]         gpio_out_q, gpio_out_d;
  logic [SW_WIDTH-1:0] s1_q, s2_q;
  logic [SW_WIDTH-1:0] sw_stable_q, sw_stable_d;
  logic [SW_WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  db_state_t           state_q, state_d;
  logic                sw_changed_q, sw_changed_d;

  always_comb begin
    gpio_out_d   = gpio_we ? gpio_wdata : gpio_out_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    sw_stable_d  = sw_stable_q;
    sw_changed_d = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (s2_q != sw_stable_q) begin
          cand_d  = s2_q;
          cnt_d   = CNT_RELOAD;
          state_d = DB_SETTLE;
        end
      end
      DB_SETTLE: begin
        // A return to the accepted value cancels the change silently.
        if (s2_q == sw_stable_q) begin
          state_d = DB_STABLE;
        end else if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          sw_stable_d  = cand_q;
          sw_changed_d = 1'b1;
          state_d      = DB_STABLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = DB_STABLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q   <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      sw_stable_q  <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      state_q      <= DB_STABLE;
      sw_changed_q <= 1'b0;
    end else begin
      gpio_out_q   <= gpio_out_d;
      s1_q         <= sw_raw;
      s2_q         <= s1_q;
      sw_stable_q  <= sw_stable_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign gpio_out   = gpio_out_q;
  assign gpio_rdata = 32'(sw_stable_q);
  assign sw_changed = sw_changed_q;

  for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_digit
    hex7seg_decode u_digit (
      .nibble (gpio_out_q[4*i +: 4]),
      .seg    (hex_seg[7*i +: 7])
    );
  end

endmodule
